// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch stage. In IDLE it accepts the
// fetch PC, waits a configurable number of cycles, then returns the addressed
// instruction word. It holds that response for as long as the pipeline stalls.
// It abandons a request when fetch redirects to a different PC before the
// response is consumed. A program-load port can write the backing array at
// any time.
//
// Parameters:
//   MEM_WORDS  number of 32-bit words in the backing array (index = addr[31:2])
//   LATENCY    cycles from request acceptance to imem_ready (1..15)
//
// Ports:
//   clk         clock, all state changes on its rising edge
//   rst         asynchronous active-high reset
//   addr        requested byte address (fetch PC)
//   stall       pipeline stall; when high, fetch does not consume the response
//   instr       instruction word returned to fetch
//   imem_ready  instr/fault are valid this cycle
//   fault       response is misaligned or out of range
//   prog_we     program-load write enable
//   prog_addr   program-load byte address (bits [1:0] ignored)
//   prog_data   program-load data
//   resp_count  number of responses consumed by fetch
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        imem_ready,
    output logic        fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic [31:0] resp_count
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [3:0]  cnt;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] load_addr;
    logic [31:0] load_word;
    logic        load_fault;
    logic [31:0] load_data;
    logic [31:0] prog_word;
    logic        prog_in_range;
    logic        unused_prog_bits;

    // The byte-offset bits of the program address carry no information.
    assign unused_prog_bits = ^prog_addr[1:0];

    // Response that would be loaded at this edge. With LATENCY=1 the load
    // happens straight out of IDLE, so the live address is used there. A
    // program write landing on the same word on the same edge is forwarded
    // so the fetched word matches what the array will hold afterwards.
    always_comb begin
        load_addr     = (state == IDLE) ? addr : req_addr;
        load_word     = {2'b00, load_addr[31:2]};
        load_fault    = (load_addr[1:0] != 2'b00) || (load_word >= 32'(MEM_WORDS));
        prog_word     = {2'b00, prog_addr[31:2]};
        prog_in_range = (prog_word < 32'(MEM_WORDS));
        load_data     = '0;
        if (load_fault) begin
            load_data = '0;
        end else if (prog_we && prog_in_range && (prog_word == load_word)) begin
            load_data = prog_data;
        end else begin
            load_data = mem[load_word[AW-1:0]];
        end
    end

    // Backing array. It is deliberately not reset so that a program loaded
    // before or during reset survives. Writes beyond the array are dropped
    // instead of wrapping onto low words.
    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
            mem[prog_word[AW-1:0]] <= prog_data;
        end
    end

    // Request/response sequencer. IDLE accepts a PC. WAIT counts down the
    // remaining latency and abandons the request if fetch moves its PC. RESP
    // holds the word until fetch consumes it (stall low) or redirects away
    // while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            cnt        <= '0;
            instr      <= '0;
            imem_ready <= 1'b0;
            fault      <= 1'b0;
            resp_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_addr <= addr;
                    cnt      <= 4'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state <= WAIT;
                    end else begin
                        state      <= RESP;
                        imem_ready <= 1'b1;
                        instr      <= load_data;
                        fault      <= load_fault;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (addr != req_addr) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state      <= RESP;
                        imem_ready <= 1'b1;
                        instr      <= load_data;
                        fault      <= load_fault;
                    end
                end
                RESP: begin
                    if (!stall) begin
                        state      <= IDLE;
                        resp_count <= resp_count + 32'd1;
                        imem_ready <= 1'b0;
                        instr      <= '0;
                        fault      <= 1'b0;
                    end else if (addr != req_addr) begin
                        state      <= IDLE;
                        imem_ready <= 1'b0;
                        instr      <= '0;
                        fault      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    imem_ready <= 1'b0;
                    instr      <= '0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Self-checking bench for imem_responder. A transaction-level reference
// (pending request + age counter + held response + word array) predicts the
// outputs after every clock edge. Directed scenarios come first, followed by
// a randomized stretch of fetch traffic, stalls and program writes.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        stall = 1'b0;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [31:0] instr;
    logic        imem_ready;
    logic        fault;
    logic [31:0] resp_count;

    imem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .LATENCY  (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .stall     (stall),
        .instr     (instr),
        .imem_ready(imem_ready),
        .fault     (fault),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .resp_count(resp_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: what fetch should see, described as a pending request
    // with an age plus a held response.
    logic [31:0] m_mem [MEM_WORDS];
    bit          m_busy;
    bit          m_ready;
    bit          m_fault;
    int          m_age;
    logic [31:0] m_req;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("imem_ready", {31'b0, imem_ready}, {31'b0, m_ready});
        checkOutput("instr", instr, m_instr);
        checkOutput("fault", {31'b0, fault}, {31'b0, m_fault});
        checkOutput("resp_count", resp_count, m_count);
    endtask

    task automatic modelReset();
        m_busy  = 0;
        m_ready = 0;
        m_fault = 0;
        m_age   = 0;
        m_req   = '0;
        m_instr = '0;
        m_count = '0;
    endtask

    // Produce the response for the pending request; a program write to the
    // same word on this edge wins.
    task automatic modelDeliver();
        logic [31:0] w;
        w       = m_req >> 2;
        m_busy  = 0;
        m_ready = 1;
        if (m_req[1:0] != 2'b00 || w >= MEM_WORDS) begin
            m_instr = '0;
            m_fault = 1;
        end else begin
            m_fault = 0;
            m_instr = (prog_we && (prog_addr >> 2) == w) ? prog_data : m_mem[w];
        end
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic modelEdge();
        if (rst) begin
            modelReset();
        end else if (m_ready) begin
            if (!stall) begin
                m_ready = 0;
                m_instr = '0;
                m_fault = 0;
                m_count = m_count + 1;
            end else if (addr != m_req) begin
                m_ready = 0;
                m_instr = '0;
                m_fault = 0;
            end
        end else if (!m_busy) begin
            m_req  = addr;
            m_age  = 1;
            m_busy = 1;
            if (m_age == LATENCY) modelDeliver();
        end else if (addr != m_req) begin
            m_busy = 0;
        end else begin
            m_age++;
            if (m_age == LATENCY) modelDeliver();
        end
        if (prog_we && (prog_addr >> 2) < MEM_WORDS) m_mem[prog_addr >> 2] = prog_data;
    endtask

    // Drive one cycle of inputs, clock it, and compare shortly after the edge.
    task automatic applyStimulus(input logic [31:0] a, input logic s, input logic we,
                                 input logic [31:0] pa, input logic [31:0] pd);
        addr      = a;
        stall     = s;
        prog_we   = we;
        prog_addr = pa;
        prog_data = pd;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
        prog_we = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic s);
        applyStimulus(a, s, 1'b0, 32'h0, 32'h0);
    endtask

    // Raise reset between edges, confirm outputs clear with no clock, hold it
    // across one edge, then release.
    task automatic asyncReset(input string tag);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, "_ready"}, {31'b0, imem_ready}, 32'h0);
        checkOutput({tag, "_instr"}, instr, 32'h0);
        checkOutput({tag, "_fault"}, {31'b0, fault}, 32'h0);
        checkOutput({tag, "_count"}, resp_count, 32'h0);
        req(addr, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] d;
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = '0;
        modelReset();

        #1 rst = 1'b1;
        #1;
        checkAll();

        // Program load during reset: words 0..63.
        for (int i = 0; i < 64; i++) begin
            d = (i == 0) ? 32'h00500093 : (i == 1) ? 32'h00100113 : $urandom;
            applyStimulus(32'h0, 1'b0, 1'b1, 32'(i * 4), d);
        end
        // Out-of-range write must be dropped, not alias onto word 0.
        applyStimulus(32'h0, 1'b0, 1'b1, 32'(MEM_WORDS * 4), 32'hBAD0BAD0);
        rst = 1'b0;

        // Two back-to-back fetches.
        req(32'h0, 1'b0);
        checkOutput("first_not_ready", {31'b0, imem_ready}, 32'h0);
        req(32'h0, 1'b0);
        checkOutput("first_instr", instr, 32'h00500093);
        req(32'h4, 1'b0);
        req(32'h4, 1'b0);
        req(32'h4, 1'b0);
        checkOutput("second_instr", instr, 32'h00100113);
        req(32'h4, 1'b0);
        checkOutput("count_two", resp_count, 32'd2);

        // Stall holds the response for three cycles.
        req(32'h0, 1'b0);
        req(32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req(32'h0, 1'b1);
            checkOutput("stall_held", instr, 32'h00500093);
        end
        req(32'h0, 1'b0);
        checkOutput("stall_consumed", resp_count, 32'd3);

        // Misaligned and out-of-range requests.
        req(32'h6, 1'b0);
        req(32'h6, 1'b0);
        checkOutput("misaligned_fault", {31'b0, fault}, 32'h1);
        req(32'h6, 1'b0);
        req(32'(MEM_WORDS * 4), 1'b0);
        req(32'(MEM_WORDS * 4), 1'b0);
        checkOutput("range_fault", {31'b0, fault}, 32'h1);
        req(32'(MEM_WORDS * 4), 1'b0);

        // Redirect while waiting.
        req(32'h0, 1'b0);
        req(32'h40, 1'b0);
        checkOutput("redirect_no_ready", {31'b0, imem_ready}, 32'h0);
        req(32'h40, 1'b0);
        req(32'h40, 1'b0);
        req(32'h40, 1'b0);

        // Write-first collision with the response load, then a write to the
        // held word while stalled.
        req(32'h8, 1'b0);
        applyStimulus(32'h8, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
        checkOutput("collision_instr", instr, 32'hDEADBEEF);
        applyStimulus(32'h8, 1'b1, 1'b1, 32'h8, 32'h12345678);
        checkOutput("held_after_write", instr, 32'hDEADBEEF);
        req(32'h8, 1'b0);

        // Stalled redirect drops the response without counting it.
        req(32'h10, 1'b0);
        req(32'h10, 1'b0);
        req(32'h14, 1'b1);
        checkOutput("stall_redirect_ready", {31'b0, imem_ready}, 32'h0);
        req(32'h14, 1'b0);
        req(32'h14, 1'b0);
        req(32'h14, 1'b0);

        // Reset while waiting, then a fresh request.
        req(32'h0, 1'b0);
        asyncReset("rst_wait");
        req(32'h0, 1'b0);
        req(32'h0, 1'b0);
        checkOutput("after_reset_instr", instr, 32'h00500093);

        // Reset while holding a response.
        asyncReset("rst_resp");
        req(32'h4, 1'b0);
        req(32'h4, 1'b0);
        req(32'h4, 1'b0);

        // Randomized fetch traffic with stalls, redirects and program writes.
        cur = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0:       cur = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
                    1:       cur = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 255) * 4);
                    default: cur = 32'($urandom_range(0, 63) * 4);
                endcase
            end
            if ($urandom_range(0, 6) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    applyStimulus(cur, ($urandom_range(0, 9) < 3), 1'b1,
                                  32'(MEM_WORDS * 4) + 32'($urandom_range(0, 63) * 4), $urandom);
                else
                    applyStimulus(cur, ($urandom_range(0, 9) < 3), 1'b1,
                                  ($urandom_range(0, 1) == 0) ? cur : 32'($urandom_range(0, 63) * 4),
                                  $urandom);
            end else begin
                req(cur, ($urandom_range(0, 9) < 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
